prbs_checker: RTL and testbench

//  Receive-side PRBS checker paired with the Fibonacci LFSR generator. Takes the serial bit stream
//  (generator data_o[0] per enabled cycle) and self-synchronises by loading received bits.

---
 rtl/prbs_checker.sv | 129 ++++++++++++
 tb/tb_prbs_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises on the incoming serial stream, then flywheels
// on a local Fibonacci predictor and counts bit errors with saturating counters.
module prbs_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] poly_i,
    input  logic                  valid_i,
    input  logic                  data_i,
    input  logic                  clear_i,
    output logic                  locked_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [CNT_WIDTH-1:0]  bit_cnt_o
);

    localparam int FILL_W  = $clog2(DATA_WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(DATA_WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        FILL,
        VERIFY,
        LOCKED
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sreg;
    logic [FILL_W-1:0]     fill_cnt;
    logic [MATCH_W-1:0]    match_cnt;
    logic [MISS_W-1:0]     miss_cnt;

    logic pred;
    logic mismatch;
    logic in_bit;
    logic err_sat;
    logic bit_sat;

    // Once locked the predictor feeds itself, so a corrupted bit never pollutes the register.
    always_comb begin
        pred     = ^(sreg & poly_i);
        mismatch = data_i ^ pred;
        in_bit   = (state == LOCKED) ? pred : data_i;
        err_sat  = &err_cnt_o;
        bit_sat  = &bit_cnt_o;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= FILL;
            sreg      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
            bit_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (valid_i) begin
                sreg <= {sreg[DATA_WIDTH-2:0], in_bit};
                case (state)
                    FILL: begin
                        if (fill_cnt == FILL_LAST) begin
                            state     <= VERIFY;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (mismatch) begin
                            state    <= FILL;
                            fill_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            miss_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!bit_sat) begin
                            bit_cnt_o <= bit_cnt_o + 1'b1;
                        end
                        if (mismatch) begin
                            err_o <= 1'b1;
                            if (!err_sat) begin
                                err_cnt_o <= err_cnt_o + 1'b1;
                            end
                            // A run of consecutive misses means the flywheel has drifted; resync.
                            if (miss_cnt == MISS_LAST) begin
                                state    <= FILL;
                                fill_cnt <= '0;
                                locked_o <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= FILL;
                        fill_cnt <= '0;
                        locked_o <= 1'b0;
                    end
                endcase
            end
            if (clear_i) begin
                err_cnt_o <= '0;
                bit_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Table-driven bench for prbs_checker: scenario records plus an array-based reference model of
// acquisition, flywheel prediction and saturating counters, checked every cycle.
module tb_prbs_checker;

    localparam int          DW      = 16;
    localparam int          LOCKN   = 8;
    localparam int          UNLOCKN = 4;
    localparam int          MAXB    = 2048;
    localparam logic [15:0] POLY    = 16'hD008;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [15:0] poly_i;
    logic        valid_i;
    logic        data_i;
    logic        clear_i;
    logic        locked_o;
    logic        err_o;
    logic [31:0] err_cnt_o;
    logic [31:0] bit_cnt_o;
    logic        sat_locked;
    logic        sat_err;
    logic [3:0]  sat_err_cnt;
    logic [3:0]  sat_bit_cnt;

    always #5 clk_i = ~clk_i;

    prbs_checker #(.DATA_WIDTH(DW), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .poly_i(poly_i), .valid_i(valid_i), .data_i(data_i),
        .clear_i(clear_i), .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
        .bit_cnt_o(bit_cnt_o)
    );

    prbs_checker #(.DATA_WIDTH(DW), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN), .CNT_WIDTH(4)) dut_sat (
        .clk_i(clk_i), .rstn_i(rstn_i), .poly_i(poly_i), .valid_i(valid_i), .data_i(data_i),
        .clear_i(clear_i), .locked_o(sat_locked), .err_o(sat_err), .err_cnt_o(sat_err_cnt),
        .bit_cnt_o(sat_bit_cnt)
    );

    typedef struct {
        int   num_bits;
        int   flip_start;
        int   flip_len;
        int   flip_stride;
        int   clear_at;
        int   valid_pct;
        int   exp_lock;
        int   exp_errs;
        int   exp_bits;
        logic exp_locked;
    } vec_t;

    vec_t vecs[9];

    int   vectors     = 0;
    int   miscompares = 0;
    logic clean[MAXB];
    logic rx[MAXB];
    logic fw[MAXB];

    int   m_vidx;
    int   m_acq;
    int   m_miss;
    int   m_err;
    int   m_bits;
    logic m_locked;
    logic m_err_o;

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    function automatic logic rx_pred(input int k);
        logic [15:0] p = POLY;
        logic        r = 1'b0;
        for (int i = 0; i < DW; i++) if (p[i]) r ^= rx[k-1-i];
        return r;
    endfunction

    function automatic logic fw_pred(input int k);
        logic [15:0] p = POLY;
        logic        r = 1'b0;
        for (int i = 0; i < DW; i++) if (p[i]) r ^= fw[k-1-i];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_vidx   = 0;
        m_acq    = 0;
        m_miss   = 0;
        m_err    = 0;
        m_bits   = 0;
        m_locked = 1'b0;
        m_err_o  = 1'b0;
    endtask

    // Acquisition is judged against the raw received history; once locked, the expected
    // stream is extended from the lock window by the recurrence alone.
    task automatic model_step(input logic v, input logic d, input logic c);
        int k;
        m_err_o = 1'b0;
        if (v) begin
            k     = m_vidx;
            rx[k] = d;
            if (!m_locked) begin
                if (k - m_acq >= DW) begin
                    if (d == rx_pred(k)) begin
                        if (k - m_acq - DW + 1 == LOCKN) begin
                            m_locked = 1'b1;
                            m_miss   = 0;
                            for (int j = 0; j < DW; j++) fw[k-j] = rx[k-j];
                        end
                    end else begin
                        m_acq = k + 1;
                    end
                end
            end else begin
                fw[k] = fw_pred(k);
                m_bits++;
                if (d != fw[k]) begin
                    m_err_o = 1'b1;
                    m_err++;
                    m_miss++;
                    if (m_miss == UNLOCKN) begin
                        m_locked = 1'b0;
                        m_acq    = k + 1;
                        m_miss   = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
            m_vidx++;
        end
        if (c) begin
            m_err  = 0;
            m_bits = 0;
        end
    endtask

    task automatic check_all();
        check_output("locked", 32'(locked_o), 32'(m_locked));
        check_output("err_pulse", 32'(err_o), 32'(m_err_o));
        check_output("err_cnt", err_cnt_o, 32'(m_err));
        check_output("bit_cnt", bit_cnt_o, 32'(m_bits));
        check_output("sat_err_cnt", 32'(sat_err_cnt), 32'(sat15(m_err)));
        check_output("sat_bit_cnt", 32'(sat_bit_cnt), 32'(sat15(m_bits)));
    endtask

    task automatic apply_stimulus(input logic v, input logic d, input logic c);
        @(negedge clk_i);
        valid_i = v;
        data_i  = d;
        clear_i = c;
        @(posedge clk_i);
        model_step(v, d, c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check_output("reset_locked", 32'(locked_o), 32'd0);
        check_output("reset_err_cnt", err_cnt_o, 32'd0);
        check_output("reset_bit_cnt", bit_cnt_o, 32'd0);
        rstn_i = 1'b1;
    endtask

    task automatic run_vector(input int idx, input vec_t t);
        int   sent;
        int   first_lock;
        int   cycles;
        int   off;
        logic v;
        logic d;
        logic flip;
        do_reset();
        sent       = 0;
        first_lock = -1;
        cycles     = 0;
        while (sent < t.num_bits && cycles < 20 * t.num_bits) begin
            v    = ($urandom_range(0, 99) < t.valid_pct);
            off  = sent - t.flip_start;
            flip = (t.flip_start >= 0) && (off >= 0) && (off % t.flip_stride == 0)
                   && (off / t.flip_stride < t.flip_len);
            d    = v ? (clean[sent] ^ flip) : 1'($urandom_range(0, 1));
            apply_stimulus(v, d, v && (sent == t.clear_at));
            if (v) sent++;
            if (first_lock < 0 && locked_o) first_lock = sent;
            cycles++;
        end
        check_output($sformatf("v%0d_bits_sent", idx), 32'(sent), 32'(t.num_bits));
        check_output($sformatf("v%0d_first_lock", idx), 32'(first_lock), 32'(t.exp_lock));
        check_output($sformatf("v%0d_final_errs", idx), err_cnt_o, 32'(t.exp_errs));
        check_output($sformatf("v%0d_final_bits", idx), bit_cnt_o, 32'(t.exp_bits));
        check_output($sformatf("v%0d_final_locked", idx), 32'(locked_o), 32'(t.exp_locked));
        check_output($sformatf("v%0d_sat_errs", idx), 32'(sat_err_cnt), 32'(sat15(t.exp_errs)));
    endtask

    initial begin
        logic [15:0] st;
        int          sent;
        int          first_lock;

        poly_i  = POLY;
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        data_i  = 1'b0;
        clear_i = 1'b0;

        st = SEED;
        for (int t = 0; t < MAXB; t++) begin
            clean[t] = st[0];
            st       = {st[14:0], ^(st & POLY)};
        end

        //          bits  fstart len str clr  pct lock errs bits  locked
        vecs[0] = '{1024, -1,    0,  1,  -1,  100, 24,  0,  1000, 1'b1};
        vecs[1] = '{300,  100,   1,  1,  -1,  100, 24,  1,  276,  1'b1};
        vecs[2] = '{300,  100,   3,  1,  -1,  100, 24,  3,  276,  1'b1};
        vecs[3] = '{300,  100,   4,  1,  -1,  100, 24,  4,  252,  1'b1};
        vecs[4] = '{300,  20,    1,  1,  -1,  100, 45,  0,  255,  1'b1};
        vecs[5] = '{300,  23,    1,  1,  -1,  100, 48,  0,  252,  1'b1};
        vecs[6] = '{300,  100,   4,  1,  -1,  50,  24,  4,  252,  1'b1};
        vecs[7] = '{300,  100,   20, 2,  -1,  100, 24,  20, 276,  1'b1};
        vecs[8] = '{300,  100,   1,  1,  100, 60,  24,  0,  199,  1'b1};

        for (int i = 0; i < 9; i++) run_vector(i, vecs[i]);

        // Asynchronous reset while locked, then relock on the continuing stream.
        do_reset();
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, clean[i], 1'b0);
        check_output("pre_reset_locked", 32'(locked_o), 32'd1);
        @(posedge clk_i);
        #3;
        rstn_i = 1'b0;
        model_reset();
        #1;
        check_output("async_locked", 32'(locked_o), 32'd0);
        check_output("async_err_cnt", err_cnt_o, 32'd0);
        check_output("async_bit_cnt", bit_cnt_o, 32'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        check_all();
        rstn_i     = 1'b1;
        sent       = 0;
        first_lock = -1;
        for (int i = 40; i < 70; i++) begin
            apply_stimulus(1'b1, clean[i], 1'b0);
            sent++;
            if (first_lock < 0 && locked_o) first_lock = sent;
        end
        check_output("relock_point", 32'(first_lock), 32'd24);
        check_output("relock_bits", bit_cnt_o, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
